fetch_sequencer: RTL and testbench

//  Multicycle fetch/PC-update controller for the Instruction Unit.
//  - Drives the unit's PC_ld, PC_inc, PC_sel, im_cs, im_rd, im_wr and ir_ld strobes.
//  - Sequences fetch -> IR load -> decode handoff -> PC redirect.
//  - Handshakes with the core control unit through ir_valid / ex_done / pc_src.

---
 rtl/fetch_sequencer_if.sv | 38 +++
 rtl/fetch_sequencer.sv | 141 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: run/halt/ex_done/pc_src handshake from the core control
// unit plus the PC, instruction-memory and IR strobes toward the Instruction Unit.
// Handshake: the core holds ex_done high while it finishes the current
// instruction; the sequencer samples ex_done and pc_src together on the rising
// edge while ir_valid=1 (DECODE). ex_done at any other time is ignored.
interface fetch_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             halt;
  logic             ex_done;
  logic [1:0]       pc_src;
  logic             PC_ld;
  logic             PC_inc;
  logic [1:0]       PC_sel;
  logic             im_cs;
  logic             im_rd;
  logic             im_wr;
  logic             ir_ld;
  logic             ir_valid;
  logic             busy;
  logic [2:0]       state;
  logic [CNT_W-1:0] fetch_count;

  // Core control unit side.
  modport master (
    output run, halt, ex_done, pc_src,
    input  PC_ld, PC_inc, PC_sel, im_cs, im_rd, im_wr, ir_ld, ir_valid,
           busy, state, fetch_count
  );

  // Sequencer side.
  modport slave (
    input  run, halt, ex_done, pc_src,
    output PC_ld, PC_inc, PC_sel, im_cs, im_rd, im_wr, ir_ld, ir_valid,
           busy, state, fetch_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Multicycle fetch / PC-update controller for the Instruction Unit.
// Sequence: FETCH (IM_WAIT+1 cycles) -> LOAD -> DECODE (wait ex_done)
//   -> FETCH, or -> UPDATE -> FETCH for a PC redirect.
// All outputs are Moore decodes of the registered state.
// Build option: define FETCH_SEQ_COUNT_EN to include the fetch_count counter;
// without it fetch_count is tied to zero.
module fetch_sequencer #(
  parameter int IM_WAIT = 0,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    DECODE = 3'd3,
    UPDATE = 3'd4,
    HALTED = 3'd5
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(IM_WAIT);

  state_t     state_q, state_d;
  logic [3:0] wait_q;
  logic [1:0] src_q;

  logic       pc_ld, pc_inc, cs, rd, ld, valid, busy;
  logic [1:0] sel;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Memory wait counter: loaded on entry to FETCH, counts down while there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q <= 4'd0;
    end else if (state_d == FETCH && state_q != FETCH) begin
      wait_q <= WAIT_INIT;
    end else if (state_q == FETCH && wait_q != 4'd0) begin
      wait_q <= wait_q - 4'd1;
    end
  end

  // Capture the redirect kind on the retiring edge so UPDATE sees a stable value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             src_q <= 2'b00;
    else if (state_q == DECODE && bus.ex_done) src_q <= bus.pc_src;
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_d = state_q;
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
    sel     = 2'b00;
    cs      = 1'b0;
    rd      = 1'b0;
    ld      = 1'b0;
    valid   = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.halt)     state_d = HALTED;
        else if (bus.run) state_d = FETCH;
      end
      FETCH: begin
        cs   = 1'b1;
        rd   = 1'b1;
        busy = 1'b1;
        if (wait_q == 4'd0) state_d = LOAD;
      end
      LOAD: begin
        cs      = 1'b1;
        rd      = 1'b1;
        ld      = 1'b1;
        pc_inc  = 1'b1;
        busy    = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        valid = 1'b1;
        busy  = 1'b1;
        if (bus.ex_done) begin
          // A halt at retirement wins and drops any pending redirect.
          if (bus.halt)                  state_d = HALTED;
          else if (bus.pc_src == 2'b00)  state_d = FETCH;
          else                           state_d = UPDATE;
        end
      end
      UPDATE: begin
        pc_ld = 1'b1;
        busy  = 1'b1;
        case (src_q)
          2'b01:   sel = 2'd1;
          2'b10:   sel = 2'd2;
          default: sel = 2'd0;
        endcase
        state_d = bus.halt ? HALTED : FETCH;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.PC_ld    = pc_ld;
  assign bus.PC_inc   = pc_inc;
  assign bus.PC_sel   = sel;
  assign bus.im_cs    = cs;
  assign bus.im_rd    = rd;
  assign bus.im_wr    = 1'b0;
  assign bus.ir_ld    = ld;
  assign bus.ir_valid = valid;
  assign bus.busy     = busy;
  assign bus.state    = state_q;

`ifdef FETCH_SEQ_COUNT_EN
  logic [CNT_W-1:0] count_q;

  // Count instructions loaded into IR; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               count_q <= '0;
    else if (state_q == LOAD) count_q <= count_q + CNT_W'(1);
  end

  assign bus.fetch_count = count_q;
`else
  assign bus.fetch_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: dut_a (IM_WAIT=0, CNT_W=4) and
// dut_b (IM_WAIT=2, CNT_W=16) share clock and reset.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic reset;

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  fetch_sequencer_if #(.CNT_W(4))  ifa ();
  fetch_sequencer_if #(.CNT_W(16)) ifb ();

  fetch_sequencer #(.IM_WAIT(0), .CNT_W(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  fetch_sequencer #(.IM_WAIT(2), .CNT_W(16)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

`ifdef FETCH_SEQ_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  int checks = 0;
  int errors = 0;

  // Expected {state, PC_ld, PC_inc, PC_sel, im_cs, im_rd, im_wr, ir_ld, ir_valid, busy}.
  function automatic logic [12:0] exp_vec(input logic [2:0] st, input logic [1:0] sel);
    logic pld, inc, cs, rd, ld, valid, busy;
    logic [1:0] s;
    pld = 1'b0; inc = 1'b0; cs = 1'b0; rd = 1'b0;
    ld = 1'b0; valid = 1'b0; busy = 1'b0; s = 2'b00;
    case (st)
      S_FETCH:  begin cs = 1'b1; rd = 1'b1; busy = 1'b1; end
      S_LOAD:   begin cs = 1'b1; rd = 1'b1; ld = 1'b1; inc = 1'b1; busy = 1'b1; end
      S_DECODE: begin valid = 1'b1; busy = 1'b1; end
      S_UPDATE: begin pld = 1'b1; busy = 1'b1; s = sel; end
      default:  begin end
    endcase
    return {st, pld, inc, s, cs, rd, 1'b0, ld, valid, busy};
  endfunction

  function automatic logic [12:0] obs_a();
    return {ifa.state, ifa.PC_ld, ifa.PC_inc, ifa.PC_sel, ifa.im_cs, ifa.im_rd,
            ifa.im_wr, ifa.ir_ld, ifa.ir_valid, ifa.busy};
  endfunction

  function automatic logic [12:0] obs_b();
    return {ifb.state, ifb.PC_ld, ifb.PC_inc, ifb.PC_sel, ifb.im_cs, ifb.im_rd,
            ifb.im_wr, ifb.ir_ld, ifb.ir_valid, ifb.busy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic chk_a(input string tag, input logic [2:0] st, input logic [1:0] sel);
    chk(tag, 32'(obs_a()), 32'(exp_vec(st, sel)));
  endtask

  task automatic chk_b(input string tag, input logic [2:0] st, input logic [1:0] sel);
    chk(tag, 32'(obs_b()), 32'(exp_vec(st, sel)));
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    ifa.run = 1'b0; ifa.halt = 1'b0; ifa.ex_done = 1'b0; ifa.pc_src = 2'b00;
    ifb.run = 1'b0; ifb.halt = 1'b0; ifb.ex_done = 1'b0; ifb.pc_src = 2'b00;

    // Reset state.
    tick();
    tick();
    chk_a("reset_a", S_IDLE, 2'd0);
    chk_b("reset_b", S_IDLE, 2'd0);
    chk("reset_cnt_a", 32'(ifa.fetch_count), 32'd0);
    reset = 1'b1;
    tick();
    chk_a("idle_a", S_IDLE, 2'd0);

    // Sequential fetches with immediate ex_done, IM_WAIT=0.
    ifa.run = 1'b1;
    tick();
    ifa.run = 1'b0;
    ifa.ex_done = 1'b1;
    ifa.pc_src = 2'b00;
    for (int i = 0; i < 3; i++) begin
      chk_a($sformatf("seq_fetch_%0d", i), S_FETCH, 2'd0);
      tick();
      chk_a($sformatf("seq_load_%0d", i), S_LOAD, 2'd0);
      tick();
      chk_a($sformatf("seq_decode_%0d", i), S_DECODE, 2'd0);
      if (i == 2) ifa.ex_done = 1'b0;
      tick();
    end
    chk_a("seq_hold_decode", S_DECODE, 2'd0);
    chk("seq_count", 32'(ifa.fetch_count), CNT_EN ? 32'd3 : 32'd0);

    // Redirects: jump, branch, register.
    ifa.ex_done = 1'b1;
    ifa.pc_src = 2'b01;
    tick();
    chk_a("upd_jump", S_UPDATE, 2'd1);
    ifa.pc_src = 2'b10;
    tick();
    chk_a("upd_jump_next", S_FETCH, 2'd0);
    tick();
    chk_a("upd_load1", S_LOAD, 2'd0);
    tick();
    chk_a("upd_decode1", S_DECODE, 2'd0);
    tick();
    chk_a("upd_branch", S_UPDATE, 2'd2);
    ifa.pc_src = 2'b11;
    tick();
    chk_a("upd_branch_next", S_FETCH, 2'd0);
    tick();
    tick();
    chk_a("upd_decode2", S_DECODE, 2'd0);
    tick();
    chk_a("upd_reg", S_UPDATE, 2'd0);
    ifa.ex_done = 1'b0;
    ifa.pc_src = 2'b00;
    tick();
    chk_a("upd_reg_next", S_FETCH, 2'd0);
    tick();
    tick();
    tick();
    chk_a("upd_hold_decode", S_DECODE, 2'd0);
    chk("upd_count", 32'(ifa.fetch_count), CNT_EN ? 32'd6 : 32'd0);

    // Halt raised during FETCH; retirement with a branch goes to HALTED.
    ifa.ex_done = 1'b1;
    tick();
    chk_a("halt_fetch", S_FETCH, 2'd0);
    ifa.halt = 1'b1;
    ifa.ex_done = 1'b0;
    tick();
    chk_a("halt_load", S_LOAD, 2'd0);
    tick();
    chk_a("halt_decode", S_DECODE, 2'd0);
    tick();
    chk_a("halt_decode_hold", S_DECODE, 2'd0);
    ifa.ex_done = 1'b1;
    ifa.pc_src = 2'b10;
    tick();
    chk_a("halt_enter", S_HALTED, 2'd0);
    ifa.ex_done = 1'b0;
    ifa.halt = 1'b0;
    ifa.run = 1'b1;
    tick();
    tick();
    chk_a("halt_sticky", S_HALTED, 2'd0);
    chk("halt_count", 32'(ifa.fetch_count), CNT_EN ? 32'd7 : 32'd0);
    ifa.run = 1'b0;

    // IM_WAIT=2: three FETCH cycles then LOAD, then DECODE.
    ifb.run = 1'b1;
    tick();
    ifb.run = 1'b0;
    chk_b("wait_fetch0", S_FETCH, 2'd0);
    tick();
    chk_b("wait_fetch1", S_FETCH, 2'd0);
    tick();
    chk_b("wait_fetch2", S_FETCH, 2'd0);
    tick();
    chk_b("wait_load", S_LOAD, 2'd0);
    tick();
    chk_b("wait_decode", S_DECODE, 2'd0);
    ifb.ex_done = 1'b1;
    tick();
    chk_b("wait_refetch0", S_FETCH, 2'd0);
    chk("wait_count", 32'(ifb.fetch_count), CNT_EN ? 32'd1 : 32'd0);
    ifb.ex_done = 1'b0;
    tick();
    chk_b("wait_refetch1", S_FETCH, 2'd0);

    // Asynchronous reset in the middle of a FETCH cycle.
    #2;
    reset = 1'b0;
    #1;
    chk_b("async_reset_b", S_IDLE, 2'd0);
    chk("async_reset_cnt_b", 32'(ifb.fetch_count), 32'd0);
    chk_a("async_reset_a", S_IDLE, 2'd0);
    chk("async_reset_cnt_a", 32'(ifa.fetch_count), 32'd0);
    tick();
    reset = 1'b1;

    // 17 fetches on a 4-bit counter wrap to 1.
    ifa.run = 1'b1;
    ifa.ex_done = 1'b1;
    ifa.pc_src = 2'b00;
    tick();
    ifa.run = 1'b0;
    for (int i = 0; i < 17; i++) begin
      chk_a($sformatf("wrap_fetch_%0d", i), S_FETCH, 2'd0);
      tick();
      chk_a($sformatf("wrap_load_%0d", i), S_LOAD, 2'd0);
      tick();
      chk_a($sformatf("wrap_decode_%0d", i), S_DECODE, 2'd0);
      chk($sformatf("wrap_count_%0d", i), 32'(ifa.fetch_count),
          CNT_EN ? 32'((i + 1) % 16) : 32'd0);
      if (i == 16) ifa.ex_done = 1'b0;
      tick();
    end
    chk("wrap_count_final", 32'(ifa.fetch_count), CNT_EN ? 32'd1 : 32'd0);

    // halt has priority over run in IDLE.
    ifb.run = 1'b1;
    ifb.halt = 1'b1;
    tick();
    chk_b("idle_halt_priority", S_HALTED, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
